// File: rtl/vigilancia_scheduler.sv
// Camera-bank sequencer: rotates groups on a dwell timer and holds motion-alarmed groups on screen.
// Optional build macro VIGILANCIA_OPERATOR_ACK_EN adds an 'ack' input that gates leaving an alarm.
module vigilancia_scheduler #(
    parameter int NGROUPS        = 3,
    parameter int CAMS_PER_GROUP = 3,
    parameter int DWELL_CYCLES   = 4,
    parameter int ALARM_HOLD     = 8,
    parameter int GW             = (NGROUPS > 1) ? $clog2(NGROUPS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
`ifdef VIGILANCIA_OPERATOR_ACK_EN
    input  logic                              ack,
`endif
    input  logic [NGROUPS*CAMS_PER_GROUP-1:0] motion,
    output logic [NGROUPS*CAMS_PER_GROUP-1:0] S,
    output logic [GW-1:0]                     group,
    output logic                              alarm,
    output logic [NGROUPS-1:0]                pending
);
    localparam int NCAMS = NGROUPS * CAMS_PER_GROUP;
    localparam int DW    = $clog2(DWELL_CYCLES) + 1;
    localparam int HW    = $clog2(ALARM_HOLD) + 1;
    localparam logic [GW-1:0] LAST_G     = GW'(NGROUPS - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(ALARM_HOLD - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_ALARM = 2'd2} state_t;

    state_t             r_state, w_state_next;
    logic [NCAMS-1:0]   r_s, w_s_next;
    logic [GW-1:0]      r_group, w_group_next;
    logic               r_alarm, w_alarm_next;
    logic [NGROUPS-1:0] r_pending, w_pending_next;
    logic [DW-1:0]      r_dwell, w_dwell_next;
    logic [HW-1:0]      r_hold, w_hold_next;
    logic [GW-1:0]      r_last, w_last_next;
    logic [NGROUPS-1:0] w_req, w_own, w_cand, w_grant_oh;
    logic               w_found, w_release;
    logic [GW-1:0]      w_grant;

    function automatic logic [GW-1:0] next_group(input logic [GW-1:0] g);
        return (g == LAST_G) ? GW'(0) : g + GW'(1);
    endfunction

    function automatic logic [NGROUPS-1:0] group_onehot(input logic [GW-1:0] g);
        logic [NGROUPS-1:0] v;
        for (int i = 0; i < NGROUPS; i++) v[i] = (GW'(i) == g);
        return v;
    endfunction

    function automatic logic [NCAMS-1:0] group_mask(input logic [GW-1:0] g);
        logic [NCAMS-1:0] m;
        for (int c = 0; c < NCAMS; c++) m[c] = (GW'(c / CAMS_PER_GROUP) == g);
        return m;
    endfunction

    function automatic logic [NGROUPS-1:0] group_req(input logic [NCAMS-1:0] mot);
        logic [NGROUPS-1:0] r;
        for (int g = 0; g < NGROUPS; g++) r[g] = |mot[g*CAMS_PER_GROUP +: CAMS_PER_GROUP];
        return r;
    endfunction

    // Round-robin pick starting after 'last'; result is {found, index}.
    function automatic logic [GW:0] rr_pick(input logic [NGROUPS-1:0] reqv, input logic [GW-1:0] last);
        logic          found;
        logic [GW-1:0] idx, cand;
        found = 1'b0;
        idx   = GW'(0);
        cand  = last;
        for (int i = 0; i < NGROUPS; i++) begin
            cand  = next_group(cand);
            idx   = (!found && reqv[cand]) ? cand : idx;
            found = found | reqv[cand];
        end
        return {found, idx};
    endfunction

`ifdef VIGILANCIA_OPERATOR_ACK_EN
    assign w_release = ack;
`else
    assign w_release = 1'b1;
`endif

    // Next-state, counter, pending and arbitration logic.
    always_comb begin
        w_state_next   = r_state;
        w_group_next   = r_group;
        w_alarm_next   = r_alarm;
        w_pending_next = r_pending;
        w_dwell_next   = r_dwell;
        w_hold_next    = r_hold;
        w_last_next    = r_last;
        w_req          = group_req(motion);
        // The held group's own motion restarts the hold instead of queuing a request.
        w_own          = (r_state == ST_ALARM) ? group_onehot(r_group) : {NGROUPS{1'b0}};
        w_cand         = (r_pending | w_req) & ~w_own;
        {w_found, w_grant} = rr_pick(w_cand, r_last);
        w_grant_oh     = group_onehot(w_grant);
        if (!enable) begin
            w_state_next   = ST_IDLE;
            w_group_next   = GW'(0);
            w_alarm_next   = 1'b0;
            w_pending_next = {NGROUPS{1'b0}};
            w_dwell_next   = DW'(0);
            w_hold_next    = HW'(0);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_SCAN;
                    w_group_next = GW'(0);
                    w_dwell_next = DW'(0);
                end
                ST_SCAN: begin
                    if (w_found) begin
                        w_state_next   = ST_ALARM;
                        w_group_next   = w_grant;
                        w_last_next    = w_grant;
                        w_alarm_next   = 1'b1;
                        w_hold_next    = HW'(0);
                        w_dwell_next   = DW'(0);
                        w_pending_next = w_cand & ~w_grant_oh;
                    end else if (r_dwell == DWELL_LAST) begin
                        w_group_next = next_group(r_group);
                        w_dwell_next = DW'(0);
                    end else begin
                        w_dwell_next = r_dwell + DW'(1);
                    end
                end
                ST_ALARM: begin
                    w_pending_next = w_cand;
                    if (w_req[r_group]) begin
                        w_hold_next = HW'(0);
                    end else if (r_hold != HOLD_LAST) begin
                        w_hold_next = r_hold + HW'(1);
                    end else if (!w_release) begin
                        w_hold_next = HOLD_LAST;
                    end else if (w_found) begin
                        w_group_next   = w_grant;
                        w_last_next    = w_grant;
                        w_hold_next    = HW'(0);
                        w_pending_next = w_cand & ~w_grant_oh;
                    end else begin
                        w_state_next = ST_SCAN;
                        w_group_next = next_group(r_group);
                        w_dwell_next = DW'(0);
                        w_hold_next  = HW'(0);
                        w_alarm_next = 1'b0;
                    end
                end
                default: begin
                    w_state_next   = ST_IDLE;
                    w_group_next   = GW'(0);
                    w_alarm_next   = 1'b0;
                    w_pending_next = {NGROUPS{1'b0}};
                    w_dwell_next   = DW'(0);
                    w_hold_next    = HW'(0);
                end
            endcase
        end
        w_s_next = (w_state_next == ST_IDLE) ? {NCAMS{1'b0}} : group_mask(w_group_next);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_s       <= {NCAMS{1'b0}};
            r_group   <= GW'(0);
            r_alarm   <= 1'b0;
            r_pending <= {NGROUPS{1'b0}};
            r_dwell   <= DW'(0);
            r_hold    <= HW'(0);
            r_last    <= LAST_G;
        end else begin
            r_state   <= w_state_next;
            r_s       <= w_s_next;
            r_group   <= w_group_next;
            r_alarm   <= w_alarm_next;
            r_pending <= w_pending_next;
            r_dwell   <= w_dwell_next;
            r_hold    <= w_hold_next;
            r_last    <= w_last_next;
        end
    end

    assign S       = r_s;
    assign group   = r_group;
    assign alarm   = r_alarm;
    assign pending = r_pending;
endmodule
